// File: rtl/core_pkg.sv
// Shared constants for the 5-stage core: control-word bit positions, the
// bubble control word and the ID/EX register update selector.
package core_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int CTRL_W       = 9;

  // id_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0], Jump}
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_JUMP     = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } ex_act_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: an instruction in ID that reads the
// destination of a load currently in EX must wait one cycle.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       flush,
  output logic       load_use,
  output logic       hazard_stall
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit      = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit      = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use     = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid
                   && (rs1_hit || rs2_hit);
    // A pending flush squashes the ID instruction, so holding it is pointless.
    hazard_stall = load_use && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squashing
// and saturating stall/flush event counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [3:0]        id_funct,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ID_EX_valid,
  output logic [XLEN-1:0]   ID_EX_PC,
  output logic [4:0]        ID_EX_Rs1,
  output logic [4:0]        ID_EX_Rs2,
  output logic [4:0]        ID_EX_Rd,
  output logic [XLEN-1:0]   ID_EX_Data1,
  output logic [XLEN-1:0]   ID_EX_Data2,
  output logic [XLEN-1:0]   ID_EX_Imm,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic [3:0]        ID_EX_Funct,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   data1_q, data1_d;
  logic [XLEN-1:0]   data2_q, data2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [3:0]        funct_q, funct_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use;
  ex_act_e           act;

  hazard_detect u_hazard_detect (
    .ex_valid     (valid_q),
    .ex_memread   (ctrl_q[CTRL_MEMREAD]),
    .ex_rd        (rd_q),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .flush        (flush),
    .load_use     (load_use),
    .hazard_stall (hazard_stall)
  );

  always_comb begin
    if (flush)         act = ACT_FLUSH;
    else if (load_use) act = ACT_STALL;
    else               act = ACT_LOAD;
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    funct_d     = funct_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (act)
      ACT_LOAD: begin
        valid_d = id_valid;
        pc_d    = id_pc;
        rs1_d   = id_rs1;
        rs2_d   = id_rs2;
        rd_d    = id_rd;
        data1_d = id_rdata1;
        data2_d = id_rdata2;
        imm_d   = id_imm;
        // An empty slot must not write registers or memory downstream.
        ctrl_d  = id_valid ? id_ctrl : CTRL_NOP;
        funct_d = id_funct;
      end
      default: begin
        // Bubble: register indices zeroed so forwarding never matches it.
        valid_d = 1'b0;
        rs1_d   = 5'd0;
        rs2_d   = 5'd0;
        rd_d    = 5'd0;
        ctrl_d  = CTRL_NOP;
        if (act == ACT_FLUSH) begin
          if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
        end else begin
          if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      ctrl_q      <= CTRL_NOP;
      funct_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      funct_q     <= funct_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_EX_valid = valid_q;
  assign ID_EX_PC    = pc_q;
  assign ID_EX_Rs1   = rs1_q;
  assign ID_EX_Rs2   = rs2_q;
  assign ID_EX_Rd    = rd_q;
  assign ID_EX_Data1 = data1_q;
  assign ID_EX_Data2 = data2_q;
  assign ID_EX_Imm   = imm_q;
  assign ID_EX_Ctrl  = ctrl_q;
  assign ID_EX_Funct = funct_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage (CNT_W=4 so counter
// saturation is reachable) checked against a slot-level reference model.
module tb_id_ex_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  localparam logic [8:0] C_ADD = 9'h104; // RegWrite, ALUOp=10
  localparam logic [8:0] C_LD  = 9'h1A8; // RegWrite, MemRead, MemtoReg, ALUSrc
  localparam logic [8:0] C_LUI = 9'h108; // RegWrite, ALUSrc

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm;
  logic [8:0]      id_ctrl;
  logic [3:0]      id_funct;
  logic            flush;
  logic            hazard_stall;
  logic            ID_EX_valid;
  logic [XLEN-1:0] ID_EX_PC;
  logic [4:0]      ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
  logic [XLEN-1:0] ID_EX_Data1, ID_EX_Data2, ID_EX_Imm;
  logic [8:0]      ID_EX_Ctrl;
  logic [3:0]      ID_EX_Funct;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_funct(id_funct), .flush(flush),
    .hazard_stall(hazard_stall), .ID_EX_valid(ID_EX_valid), .ID_EX_PC(ID_EX_PC),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_Data1(ID_EX_Data1), .ID_EX_Data2(ID_EX_Data2), .ID_EX_Imm(ID_EX_Imm),
    .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_Funct(ID_EX_Funct),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic            u1, u2;
    logic [XLEN-1:0] d1, d2, imm;
    logic [8:0]      ctrl;
    logic [3:0]      funct;
    logic            flush;
  } instr_t;

  // Reference model: what EX should hold, plus event tallies.
  instr_t m_ex;
  logic   m_bubble;
  int     m_stalls, m_flushes;
  instr_t cur;
  int     checks = 0;
  int     errors = 0;
  logic   last_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic [8:0] ctrl, input logic fl);
    instr_t t;
    t.valid = v;  t.rd = rd;  t.rs1 = rs1;  t.rs2 = rs2;  t.u1 = u1;  t.u2 = u2;
    t.ctrl = ctrl;  t.flush = fl;
    t.pc    = {$urandom, $urandom};
    t.d1    = {$urandom, $urandom};
    t.d2    = {$urandom, $urandom};
    t.imm   = {$urandom, $urandom};
    t.funct = 4'($urandom);
    return t;
  endfunction

  task automatic apply(input instr_t t);
    cur = t;
    id_valid = t.valid;  id_pc = t.pc;  id_rs1 = t.rs1;  id_rs2 = t.rs2;  id_rd = t.rd;
    id_uses_rs1 = t.u1;  id_uses_rs2 = t.u2;  id_rdata1 = t.d1;  id_rdata2 = t.d2;
    id_imm = t.imm;  id_ctrl = t.ctrl;  id_funct = t.funct;  flush = t.flush;
  endtask

  task automatic model_reset();
    m_ex = '{valid: 1'b0, pc: '0, rs1: '0, rs2: '0, rd: '0, u1: 1'b0, u2: 1'b0,
             d1: '0, d2: '0, imm: '0, ctrl: '0, funct: '0, flush: 1'b0};
    m_bubble  = 1'b0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // The ID instruction needs a register that the load sitting in EX has not produced yet.
  function automatic logic needs_load_result(input instr_t id, input instr_t ex);
    logic reads;
    reads = (id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd);
    return ex.valid && ex.ctrl[7] && ex.rd != 0 && id.valid && reads;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(ID_EX_valid), 64'(m_ex.valid));
    chk({tag, ".rd"},    64'(ID_EX_Rd),    64'(m_ex.rd));
    chk({tag, ".rs1"},   64'(ID_EX_Rs1),   64'(m_ex.rs1));
    chk({tag, ".rs2"},   64'(ID_EX_Rs2),   64'(m_ex.rs2));
    chk({tag, ".ctrl"},  64'(ID_EX_Ctrl),  64'(m_ex.ctrl));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stalls));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flushes));
    if (!m_bubble) begin
      chk({tag, ".pc"},    ID_EX_PC,    m_ex.pc);
      chk({tag, ".d1"},    ID_EX_Data1, m_ex.d1);
      chk({tag, ".d2"},    ID_EX_Data2, m_ex.d2);
      chk({tag, ".imm"},   ID_EX_Imm,   m_ex.imm);
      chk({tag, ".funct"}, 64'(ID_EX_Funct), 64'(m_ex.funct));
    end
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step(input string tag);
    logic lu, exp_stall;
    lu        = needs_load_result(cur, m_ex);
    exp_stall = lu && !cur.flush;
    #1;
    chk({tag, ".hazard_stall"}, 64'(hazard_stall), 64'(exp_stall));
    @(posedge clk);
    if (cur.flush || lu) begin
      m_ex.valid = 1'b0;  m_ex.rs1 = 0;  m_ex.rs2 = 0;  m_ex.rd = 0;  m_ex.ctrl = 0;
      m_bubble = 1'b1;
      if (cur.flush) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
      else           m_stalls  = (m_stalls  < CMAX) ? m_stalls  + 1 : CMAX;
    end else begin
      m_ex = cur;
      if (!cur.valid) m_ex.ctrl = 0;
      m_bubble = 1'b0;
    end
    #1;
    check_outputs(tag);
    $display("step %-10s id_rd=%0d rs1=%0d rs2=%0d fl=%0b stall=%0b -> ex_valid=%0b ex_rd=%0d stall_cnt=%0d flush_cnt=%0d",
             tag, cur.rd, cur.rs1, cur.rs2, cur.flush, exp_stall, ID_EX_valid, ID_EX_Rd,
             stall_cnt, flush_cnt);
    last_stall = exp_stall;
    @(negedge clk);
  endtask

  initial begin
    instr_t t;
    rst_n = 1'b0;
    model_reset();
    apply(mk(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, C_ADD, 1'b0));
    repeat (2) @(posedge clk);
    #2;
    check_outputs("reset");
    chk("reset.hazard_stall", 64'(hazard_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x5,x1,x2
    apply(mk(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, C_ADD, 1'b0));
    step("add");
    chk("add.regwrite", 64'(ID_EX_Ctrl[8]), 64'd1);

    // ld x5,0(x1); add x6,x5,x7 -> one bubble then the add
    apply(mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, C_LD, 1'b0));
    step("ld");
    apply(mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, C_ADD, 1'b0));
    step("lu_stall");
    chk("lu_stall.bubble_valid", 64'(ID_EX_valid), 64'd0);
    step("lu_replay");
    chk("lu_replay.rd", 64'(ID_EX_Rd), 64'd6);
    chk("lu_replay.stall_cnt", 64'(stall_cnt), 64'd1);

    // ld x0 then a use of x0: no stall
    apply(mk(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, C_LD, 1'b0));
    step("ld_x0");
    apply(mk(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, C_ADD, 1'b0));
    step("use_x0");

    // ld x5 then lui x5 (no source reads): no stall
    apply(mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, C_LD, 1'b0));
    step("ld_x5");
    apply(mk(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_LUI, 1'b0));
    step("lui_x5");

    // Invalid slot: fields captured, control forced off
    apply(mk(1'b0, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, C_LD, 1'b0));
    step("invalid");

    // Flush wins over a simultaneous load-use
    apply(mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, C_LD, 1'b0));
    step("ld_f");
    apply(mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, C_ADD, 1'b1));
    step("flush_lu");
    chk("flush_lu.flush_cnt", 64'(flush_cnt), 64'd1);
    chk("flush_lu.stall_cnt", 64'(stall_cnt), 64'd1);

    // Asynchronous reset mid-cycle with a pending hazard on the inputs
    apply(mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, C_LD, 1'b0));
    step("ld_r");
    apply(mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, C_ADD, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.hazard_stall", 64'(hazard_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: more load-use stalls than the 4-bit counter can hold
    for (int i = 0; i < 17; i++) begin
      apply(mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, C_LD, 1'b0));
      step("sat_ld");
      apply(mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, C_ADD, 1'b0));
      step("sat_stall");
      step("sat_replay");
    end
    chk("sat.stall_cnt", 64'(stall_cnt), 64'd15);

    // Random traffic; a stalled instruction is re-presented unchanged
    for (int i = 0; i < 400; i++) begin
      if (last_stall) begin
        t = cur;
        t.flush = ($urandom_range(0, 9) == 0);
      end else begin
        t = mk($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 9'($urandom),
               $urandom_range(0, 9) == 0);
        t.ctrl[7] = ($urandom_range(0, 9) < 4);
      end
      apply(t);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
